y86_mem_arbiter: RTL and testbench

- Shares one single-port, 64-bit, variable-latency memory bus between the fetch stage (10-byte instruction read) and the memory stage (8-byte read/write).
- The memory stage has priority, with alternation on ties so fetch cannot starve.
- Fetch is split into two bus beats.
- f_wait and m_wait feed the pipeline control logic as additional F/D and M/W stall sources.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/y86_mem_arbiter_if.sv | 21 ++
 rtl/y86_fetch_buf.sv | 37 +++
 rtl/y86_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared types and constants for the Y86 memory arbiter and its fetch buffer.
package y86_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_M_ACC,
        ARB_F_LO,
        ARB_F_HI,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        GRANT_F = 1'b0,
        GRANT_M = 1'b1
    } grant_e;

    localparam int INSTR_BYTES = 10;
    localparam int WORD_BYTES  = 8;
    localparam int INSTR_W     = INSTR_BYTES * 8;

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Single-port 64-bit memory bus shared by fetch and memory stages.
interface y86_mem_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic [63:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/y86_fetch_buf.sv
// One-entry instruction buffer keyed by fetch PC; only built with Y86_FETCH_BUF_EN.
module y86_fetch_buf
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fill_i,
    input  logic [ADDR_W-1:0]  fill_tag_i,
    input  logic [INSTR_W-1:0] fill_data_i,
    input  logic               inval_i,
    input  logic [ADDR_W-1:0]  lookup_tag_i,
    output logic               hit_o,
    output logic [INSTR_W-1:0] data_o
);
    logic               valid_q;
    logic [ADDR_W-1:0]  tag_q;
    logic [INSTR_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;
endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbitrates fetch (two-beat, 10-byte) and memory-stage (one-beat) accesses onto one bus.
// Optional one-entry fetch buffer enabled by defining Y86_FETCH_BUF_EN.
module y86_mem_arbiter
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 8192
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               f_req_i,
    input  logic [ADDR_W-1:0]  f_pc_i,
    output logic [INSTR_W-1:0] f_instr_o,
    output logic               f_done_o,
    output logic               f_err_o,
    input  logic               m_req_i,
    input  logic               m_we_i,
    input  logic [ADDR_W-1:0]  m_addr_i,
    input  logic [63:0]        m_wdata_i,
    output logic [63:0]        m_rdata_o,
    output logic               m_done_o,
    output logic               m_err_o,
    output logic               f_wait_o,
    output logic               m_wait_o,
    y86_mem_arbiter_if.master  bus
);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    arb_state_e         state_q, state_d;
    grant_e             last_grant_q, last_grant_d;
    logic               err_q, err_d;
    logic [INSTR_W-1:0] f_instr_q, f_instr_d;
    logic [63:0]        m_rdata_q, m_rdata_d;
    logic [ADDR_W-1:0]  f_pc_q, f_pc_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [63:0]        bus_wdata_q, bus_wdata_d;

    logic               grant_m, grant_f;
    logic               m_range_err, f_range_err;
    logic               buf_hit;
    logic [INSTR_W-1:0] buf_data;

    // Extra top bit keeps addr+len from wrapping near the top of the address space.
    assign m_range_err = ({1'b0, m_addr_i} + (ADDR_W+1)'(WORD_BYTES))  > MEM_LIMIT;
    assign f_range_err = ({1'b0, f_pc_i}   + (ADDR_W+1)'(INSTR_BYTES)) > MEM_LIMIT;

    // Memory stage wins ties unless it also won the previous grant.
    assign grant_m = m_req_i && (!f_req_i || (last_grant_q != GRANT_M));
    assign grant_f = f_req_i && !grant_m;

`ifdef Y86_FETCH_BUF_EN
    logic buf_fill, buf_inval;

    assign buf_fill  = (state_q == ARB_RESP) && (last_grant_q == GRANT_F) && !err_q;
    assign buf_inval = (state_q == ARB_IDLE) && grant_m && m_we_i;

    y86_fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_i       (buf_fill),
        .fill_tag_i   (f_pc_q),
        .fill_data_i  (f_instr_q),
        .inval_i      (buf_inval),
        .lookup_tag_i (f_pc_i),
        .hit_o        (buf_hit),
        .data_o       (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_F;
            err_q        <= 1'b0;
            f_instr_q    <= '0;
            m_rdata_q    <= '0;
            f_pc_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            f_instr_q    <= f_instr_d;
            m_rdata_q    <= m_rdata_d;
            f_pc_q       <= f_pc_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        f_instr_d    = f_instr_q;
        m_rdata_d    = m_rdata_q;
        f_pc_d       = f_pc_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_m) begin
                    last_grant_d = GRANT_M;
                    if (m_range_err) begin
                        err_d     = 1'b1;
                        m_rdata_d = '0;
                        state_d   = ARB_RESP;
                    end else begin
                        err_d       = 1'b0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = m_we_i;
                        bus_addr_d  = m_addr_i;
                        bus_wdata_d = m_wdata_i;
                        state_d     = ARB_M_ACC;
                    end
                end else if (grant_f) begin
                    last_grant_d = GRANT_F;
                    f_pc_d       = f_pc_i;
                    if (f_range_err) begin
                        err_d     = 1'b1;
                        f_instr_d = '0;
                        state_d   = ARB_RESP;
                    end else if (buf_hit) begin
                        err_d     = 1'b0;
                        f_instr_d = buf_data;
                        state_d   = ARB_RESP;
                    end else begin
                        err_d      = 1'b0;
                        bus_req_d  = 1'b1;
                        bus_we_d   = 1'b0;
                        bus_addr_d = f_pc_i;
                        state_d    = ARB_F_LO;
                    end
                end
            end
            ARB_M_ACC: begin
                if (bus.bus_ack) begin
                    if (!bus_we_q) begin
                        m_rdata_d = bus.bus_rdata;
                    end
                    bus_req_d = 1'b0;
                    state_d   = ARB_RESP;
                end
            end
            ARB_F_LO: begin
                if (bus.bus_ack) begin
                    f_instr_d[63:0] = bus.bus_rdata;
                    bus_addr_d      = f_pc_q + ADDR_W'(WORD_BYTES);
                    state_d         = ARB_F_HI;
                end
            end
            ARB_F_HI: begin
                if (bus.bus_ack) begin
                    f_instr_d[INSTR_W-1:64] = bus.bus_rdata[INSTR_W-65:0];
                    bus_req_d               = 1'b0;
                    state_d                 = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign f_done_o  = (state_q == ARB_RESP) && (last_grant_q == GRANT_F);
    assign m_done_o  = (state_q == ARB_RESP) && (last_grant_q == GRANT_M);
    assign f_err_o   = f_done_o && err_q;
    assign m_err_o   = m_done_o && err_q;
    assign f_instr_o = f_instr_q;
    assign m_rdata_o = m_rdata_q;
    assign f_wait_o  = f_req_i && !f_done_o;
    assign m_wait_o  = m_req_i && !m_done_o;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter with a behavioural variable-latency bus memory.
module tb_y86_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        f_req = 1'b0;
    logic [63:0] f_pc = '0;
    logic [79:0] f_instr;
    logic        f_done, f_err;
    logic        m_req = 1'b0;
    logic        m_we = 1'b0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_rdata;
    logic        m_done, m_err, f_wait, m_wait;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mem [logic [63:0]];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [63:0] beat_addr [$];
    logic        beat_we [$];

    always #5 clk = ~clk;

    y86_mem_arbiter_if #(.ADDR_W(64)) bus_if ();

    y86_mem_arbiter #(.ADDR_W(64), .MEM_BYTES(8192)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req_i   (f_req),
        .f_pc_i    (f_pc),
        .f_instr_o (f_instr),
        .f_done_o  (f_done),
        .f_err_o   (f_err),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_rdata_o (m_rdata),
        .m_done_o  (m_done),
        .m_err_o   (m_err),
        .f_wait_o  (f_wait),
        .m_wait_o  (m_wait),
        .bus       (bus_if)
    );

    // Bus memory: ack after ack_delay waiting cycles, driven on the falling edge.
    always @(negedge clk) begin
        if (bus_if.bus_req === 1'b1 && wait_cnt >= ack_delay) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = mem.exists(bus_if.bus_addr) ? mem[bus_if.bus_addr] : 64'h0;
        end else begin
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = 64'h0;
        end
    end

    always @(posedge clk) begin
        if (bus_if.bus_req === 1'b1 && bus_if.bus_ack === 1'b1) begin
            beat_addr.push_back(bus_if.bus_addr);
            beat_we.push_back(bus_if.bus_we);
            if (bus_if.bus_we) mem[bus_if.bus_addr] = bus_if.bus_wdata;
            wait_cnt = 0;
        end else if (bus_if.bus_req === 1'b1) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit want_m, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (((want_m ? m_done : f_done) !== 1'b1) && cyc < 40);
    endtask

    task automatic wait_fhi(input logic [63:0] hi_addr);
        int n;
        n = 0;
        while (!(bus_if.bus_req === 1'b1 && bus_if.bus_addr === hi_addr) && n < 40) begin
            step();
            n++;
        end
        check("reach_f_hi", 80'(n < 40), 80'd1);
    endtask

    initial begin
        int cyc;
        int n;
        int seen;
        int order [$];
        int exp_ord [4];

        mem[64'h100]  = 64'h1122334455667788;
        mem[64'h40]   = 64'hAABBCCDDEEFF0011;
        mem[64'h48]   = 64'h0000000000003344;
        mem[64'h300]  = 64'h0123456789ABCDEF;
        mem[64'h1FF8] = 64'h0BADF00DDEADBEEF;
        mem[64'h140]  = 64'h1020304050607080;
        mem[64'h148]  = 64'hFFFFFFFFFFFF5566;

        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_f_done", 80'(f_done), 80'd0);
        check("rst_m_done", 80'(m_done), 80'd0);
        check("rst_bus_req", 80'(bus_if.bus_req), 80'd0);
        check("rst_bus_addr", 80'(bus_if.bus_addr), 80'd0);
        check("rst_f_instr", f_instr, 80'd0);
        check("rst_m_rdata", 80'(m_rdata), 80'd0);
        rst_n = 1'b1;
        step();

        // Lone memory-stage read, zero-wait ack
        beat_addr.delete(); beat_we.delete();
        m_we = 1'b0; m_addr = 64'h100; m_req = 1'b1;
        wait_done(1'b1, cyc);
        check("m_rd_lat", 80'(cyc), 80'd2);
        check("m_rd_data", 80'(m_rdata), 80'h1122334455667788);
        check("m_rd_err", 80'(m_err), 80'd0);
        check("m_wait_at_done", 80'(m_wait), 80'd0);
        m_req = 1'b0;
        step();
        check("m_rd_beats", 80'(beat_addr.size()), 80'd1);
        check("m_rd_addr", 80'(beat_addr[0]), 80'h100);

        // Two-beat fetch
        beat_addr.delete(); beat_we.delete();
        f_pc = 64'h40; f_req = 1'b1;
        #1 check("f_wait_pending", 80'(f_wait), 80'd1);
        wait_done(1'b0, cyc);
        check("f_lat", 80'(cyc), 80'd3);
        check("f_instr", f_instr, 80'h3344AABBCCDDEEFF0011);
        check("f_err", 80'(f_err), 80'd0);
        f_req = 1'b0;
        step();
        check("f_beats", 80'(beat_addr.size()), 80'd2);
        check("f_beat0", 80'(beat_addr[0]), 80'h40);
        check("f_beat1", 80'(beat_addr[1]), 80'h48);

        // Both requesting continuously: M, F, M, F
        exp_ord = '{1, 0, 1, 0};
        order.delete();
        f_pc = 64'h80; m_addr = 64'h200; m_we = 1'b0;
        f_req = 1'b1; m_req = 1'b1;
        n = 0;
        while (order.size() < 4 && n < 100) begin
            step();
            n++;
            if (m_done) order.push_back(1);
            if (f_done) order.push_back(0);
        end
        f_req = 1'b0; m_req = 1'b0;
        check("alt_count", 80'(order.size()), 80'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_grant%0d", i), 80'(order[i]), 80'(exp_ord[i]));
        end
        repeat (3) step();

        // m_req arrives during F_HI with slow bus: fetch completes first
        beat_addr.delete(); beat_we.delete();
        order.delete();
        ack_delay = 3;
        f_pc = 64'hC0; f_req = 1'b1;
        wait_fhi(64'hC8);
        m_addr = 64'h300; m_we = 1'b0; m_req = 1'b1;
        n = 0;
        while (order.size() < 2 && n < 80) begin
            step();
            n++;
            if (f_done) begin order.push_back(0); f_req = 1'b0; end
            if (m_done) begin order.push_back(1); m_req = 1'b0; end
        end
        check("nopre_count", 80'(order.size()), 80'd2);
        check("nopre_first", 80'(order[0]), 80'd0);
        check("nopre_second", 80'(order[1]), 80'd1);
        check("nopre_rdata", 80'(m_rdata), 80'h0123456789ABCDEF);
        check("nopre_beats", 80'(beat_addr.size()), 80'd3);
        check("nopre_beat2", 80'(beat_addr[2]), 80'h300);
        ack_delay = 0;
        step();

        // Range errors and the last valid M word
        beat_addr.delete(); beat_we.delete();
        m_addr = 64'd8188; m_req = 1'b1;
        wait_done(1'b1, cyc);
        check("m_oor_lat", 80'(cyc), 80'd1);
        check("m_oor_err", 80'(m_err), 80'd1);
        check("m_oor_rdata", 80'(m_rdata), 80'd0);
        m_req = 1'b0;
        step();
        f_pc = 64'd8183; f_req = 1'b1;
        wait_done(1'b0, cyc);
        check("f_oor_lat", 80'(cyc), 80'd1);
        check("f_oor_err", 80'(f_err), 80'd1);
        check("f_oor_instr", f_instr, 80'd0);
        f_req = 1'b0;
        step();
        check("oor_no_beats", 80'(beat_addr.size()), 80'd0);
        m_addr = 64'd8184; m_req = 1'b1;
        wait_done(1'b1, cyc);
        check("m_edge_lat", 80'(cyc), 80'd2);
        check("m_edge_err", 80'(m_err), 80'd0);
        check("m_edge_rdata", 80'(m_rdata), 80'h0BADF00DDEADBEEF);
        m_req = 1'b0;
        step();

        // Reset during F_HI abandons the fetch
        ack_delay = 3;
        f_pc = 64'h140; f_req = 1'b1;
        wait_fhi(64'h148);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_req", 80'(bus_if.bus_req), 80'd0);
        check("mid_rst_bus_addr", 80'(bus_if.bus_addr), 80'd0);
        check("mid_rst_f_instr", f_instr, 80'd0);
        check("mid_rst_m_rdata", 80'(m_rdata), 80'd0);
        f_req = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            step();
            if (f_done) seen = 1;
        end
        check("mid_rst_no_done", 80'(seen), 80'd0);
        ack_delay = 0;
        beat_addr.delete(); beat_we.delete();
        f_req = 1'b1;
        wait_done(1'b0, cyc);
        check("refetch_lat", 80'(cyc), 80'd3);
        check("refetch_instr", f_instr, 80'h55661020304050607080);
        f_req = 1'b0;
        step();
        check("refetch_beats", 80'(beat_addr.size()), 80'd2);

`ifdef Y86_FETCH_BUF_EN
        beat_addr.delete(); beat_we.delete();
        f_req = 1'b1;
        wait_done(1'b0, cyc);
        check("buf_hit_lat", 80'(cyc), 80'd1);
        check("buf_hit_instr", f_instr, 80'h55661020304050607080);
        f_req = 1'b0;
        step();
        check("buf_hit_beats", 80'(beat_addr.size()), 80'd0);
`endif

        // Memory-stage write leaves m_rdata alone
        beat_addr.delete(); beat_we.delete();
        m_we = 1'b1; m_addr = 64'h500; m_wdata = 64'hCAFEBABE00C0FFEE; m_req = 1'b1;
        wait_done(1'b1, cyc);
        check("m_wr_lat", 80'(cyc), 80'd2);
        check("m_wr_err", 80'(m_err), 80'd0);
        check("m_wr_rdata_held", 80'(m_rdata), 80'd0);
        m_req = 1'b0; m_we = 1'b0;
        step();
        check("m_wr_beat_we", 80'(beat_we[0]), 80'd1);
        check("m_wr_mem", 80'(mem[64'h500]), 80'hCAFEBABE00C0FFEE);

        // Fetch after a write always goes to the bus
        beat_addr.delete(); beat_we.delete();
        f_pc = 64'h140; f_req = 1'b1;
        wait_done(1'b0, cyc);
        check("post_wr_f_lat", 80'(cyc), 80'd3);
        check("post_wr_f_instr", f_instr, 80'h55661020304050607080);
        f_req = 1'b0;
        step();
        check("post_wr_f_beats", 80'(beat_addr.size()), 80'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
